// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 default timing constants, counter types and window helpers
// shared by the VGA timing generator and its sub-blocks.
`default_nettype none

package vga_timing_pkg;

  localparam int CNT_W     = 10;
  localparam int CNT_LIMIT = 1 << CNT_W;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [CNT_W-1:0] cnt_t;
  // One extra bit so window bounds equal to CNT_LIMIT still compare correctly.
  typedef logic [CNT_W:0]   win_t;

  function automatic int total4(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  function automatic logic in_window(input cnt_t v, input int lo, input int len);
    return ({1'b0, v} >= win_t'(lo)) && ({1'b0, v} < win_t'(lo + len));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register for active-low sync strobes; all stages
// reset to 1 (inactive). DEPTH=0 is a straight wire.
`default_nettype none

module sync_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [DEPTH-1:0] r_stage;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stage <= '1;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running 10-bit pixel/line counters with blank, sync, line/frame
// strobes and a completed-frame counter; hs/vs are delayed to match pixel-path latency.
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int SYNC_DELAY = 2
) (
  input  logic             vga_clk,
  input  logic             reset,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             blank,
  output logic             hs,
  output logic             vs,
  output logic             sync,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_count
);

  localparam int H_TOTAL = total4(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total4(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  generate
    if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
      $error("vga_timing_gen: SYNC_DELAY must be within 0..7");
    end
  endgenerate

  localparam cnt_t c_X_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t c_Y_LAST = cnt_t'(V_TOTAL - 1);

  cnt_t        r_x;
  cnt_t        r_y;
  logic [15:0] r_frames;

  logic w_x_last;
  logic w_y_last;
  logic w_hsync_raw;
  logic w_vsync_raw;

  assign w_x_last = (r_x == c_X_LAST);
  assign w_y_last = (r_y == c_Y_LAST);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_frames <= '0;
    end else if (w_x_last) begin
      r_x <= '0;
      if (w_y_last) begin
        r_y      <= '0;
        r_frames <= r_frames + 16'd1;
      end else begin
        r_y <= r_y + cnt_t'(1);
      end
    end else begin
      r_x <= r_x + cnt_t'(1);
    end
  end

  assign w_hsync_raw = ~in_window(r_x, H_VISIBLE + H_FRONT, H_SYNC);
  assign w_vsync_raw = ~in_window(r_y, V_VISIBLE + V_FRONT, V_SYNC);

  sync_delay_line #(.DEPTH(SYNC_DELAY)) u_hs_delay (
    .clk (vga_clk),
    .rst (reset),
    .i_d (w_hsync_raw),
    .o_q (hs)
  );

  sync_delay_line #(.DEPTH(SYNC_DELAY)) u_vs_delay (
    .clk (vga_clk),
    .rst (reset),
    .i_d (w_vsync_raw),
    .o_q (vs)
  );

  // Strobes are decoded from the counters but held low while reset is asserted.
  assign blank       = ~reset && in_window(r_x, 0, H_VISIBLE) && in_window(r_y, 0, V_VISIBLE);
  assign line_start  = ~reset && (r_x == '0);
  assign frame_start = ~reset && (r_x == '0) && (r_y == '0);

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign frame_count = r_frames;
  assign sync        = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: reduced-size timing (24x10) with SYNC_DELAY=2 and SYNC_DELAY=0
// instances, checked against a time-index reference model plus a hand-derived vector table.
`default_nettype none

module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic [9:0]  dx, dy, dx0, dy0;
  logic        blank, hs, vs, sync, ls, fs;
  logic        blank0, hs0, vs0, sync0, ls0, fs0;
  logic [15:0] fc, fc0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_DELAY(2)
  ) dut (
    .vga_clk(clk), .reset(reset), .DrawX(dx), .DrawY(dy), .blank(blank),
    .hs(hs), .vs(vs), .sync(sync), .line_start(ls), .frame_start(fs),
    .frame_count(fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_DELAY(0)
  ) dut0 (
    .vga_clk(clk), .reset(reset), .DrawX(dx0), .DrawY(dy0), .blank(blank0),
    .hs(hs0), .vs(vs0), .sync(sync0), .line_start(ls0), .frame_start(fs0),
    .frame_count(fc0)
  );

  typedef struct {
    int t; int x; int y;
    bit b; bit ls; bit fs; bit hs; bit hs0; bit vs; bit vs0;
    int fc;
  } vec_t;

  vec_t tbl[18];
  int   n_pass  = 0;
  int   n_total = 0;
  int   t       = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
  endtask

  function automatic bit raw_h(input int x);
    return (x >= HV + HF && x < HV + HF + HS) ? 1'b0 : 1'b1;
  endfunction

  function automatic bit raw_v(input int y);
    return (y >= VV + VF && y < VV + VF + VS) ? 1'b0 : 1'b1;
  endfunction

  // Expected outputs derived purely from clocks elapsed since reset release.
  task automatic check_model(input bit in_rst);
    int x, y, f;
    bit eb, els, efs, eh, ev, eh0, ev0;
    if (in_rst) begin
      x = 0; y = 0; f = 0; eb = 0; els = 0; efs = 0;
      eh = 1; ev = 1; eh0 = 1; ev0 = 1;
    end else begin
      x   = t % HT;
      y   = (t / HT) % VT;
      f   = (t / FT) % 65536;
      eb  = (x < HV) && (y < VV);
      els = (x == 0);
      efs = (x == 0) && (y == 0);
      eh0 = raw_h(x);
      ev0 = raw_v(y);
      eh  = (t >= 2) ? raw_h((t - 2) % HT) : 1'b1;
      ev  = (t >= 2) ? raw_v(((t - 2) / HT) % VT) : 1'b1;
    end
    chk("DrawX", int'(dx), x);
    chk("DrawY", int'(dy), y);
    chk("blank", int'(blank), int'(eb));
    chk("line_start", int'(ls), int'(els));
    chk("frame_start", int'(fs), int'(efs));
    chk("frame_count", int'(fc), f);
    chk("hs_d2", int'(hs), int'(eh));
    chk("vs_d2", int'(vs), int'(ev));
    chk("sync", int'(sync), 0);
    chk("DrawX_d0", int'(dx0), x);
    chk("DrawY_d0", int'(dy0), y);
    chk("blank_d0", int'(blank0), int'(eb));
    chk("line_start_d0", int'(ls0), int'(els));
    chk("frame_start_d0", int'(fs0), int'(efs));
    chk("frame_count_d0", int'(fc0), f);
    chk("hs_d0", int'(hs0), int'(eh0));
    chk("vs_d0", int'(vs0), int'(ev0));
    chk("sync_d0", int'(sync0), 0);
  endtask

  task automatic step();
    @(negedge clk);
    t++;
    #1;
    check_model(1'b0);
  endtask

  initial begin
    //          t    x  y  b ls fs hs hs0 vs vs0 fc
    tbl[0]  = '{0,   0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    tbl[1]  = '{15, 15, 0, 1, 0, 0, 1, 1, 1, 1, 0};
    tbl[2]  = '{16, 16, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    tbl[3]  = '{18, 18, 0, 0, 0, 0, 1, 0, 1, 1, 0};
    tbl[4]  = '{20, 20, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[5]  = '{21, 21, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    tbl[6]  = '{22, 22, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    tbl[7]  = '{23, 23, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    tbl[8]  = '{24,  0, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    tbl[9]  = '{135,15, 5, 1, 0, 0, 1, 1, 1, 1, 0};
    tbl[10] = '{144, 0, 6, 0, 1, 0, 1, 1, 1, 1, 0};
    tbl[11] = '{168, 0, 7, 0, 1, 0, 1, 1, 1, 0, 0};
    tbl[12] = '{170, 2, 7, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[13] = '{216, 0, 9, 0, 1, 0, 1, 1, 0, 1, 0};
    tbl[14] = '{218, 2, 9, 0, 0, 0, 1, 1, 1, 1, 0};
    tbl[15] = '{239,23, 9, 0, 0, 0, 1, 1, 1, 1, 0};
    tbl[16] = '{240, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    tbl[17] = '{263,23, 0, 0, 0, 0, 1, 1, 1, 1, 1};

    repeat (3) @(negedge clk);
    #1;
    check_model(1'b1);

    @(negedge clk);
    reset = 1'b0;
    t     = 0;
    #1;
    check_model(1'b0);

    for (int k = 0; k < 18; k++) begin
      while (t < tbl[k].t) step();
      chk("vec_x", int'(dx), tbl[k].x);
      chk("vec_y", int'(dy), tbl[k].y);
      chk("vec_blank", int'(blank), int'(tbl[k].b));
      chk("vec_line_start", int'(ls), int'(tbl[k].ls));
      chk("vec_frame_start", int'(fs), int'(tbl[k].fs));
      chk("vec_hs", int'(hs), int'(tbl[k].hs));
      chk("vec_hs0", int'(hs0), int'(tbl[k].hs0));
      chk("vec_vs", int'(vs), int'(tbl[k].vs));
      chk("vec_vs0", int'(vs0), int'(tbl[k].vs0));
      chk("vec_frame_count", int'(fc), tbl[k].fc);
    end

    // Asynchronous reset mid-frame: outputs must drop before the next clock edge.
    while (t < FT + 4 * HT + 10) step();
    chk("pre_reset_x", int'(dx), 10);
    chk("pre_reset_y", int'(dy), 4);
    #2 reset = 1'b1;
    #1;
    check_model(1'b1);
    repeat (2) @(negedge clk);
    #1;
    check_model(1'b1);
    reset = 1'b0;
    t     = 0;
    #1;
    check_model(1'b0);
    repeat (1000) step();

    // Randomly timed reset pulses of random length during free running.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b1;
        #1;
        check_model(1'b1);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b0;
        t     = 0;
        #1;
        check_model(1'b0);
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
